// File: rtl/bus_arbiter_2m.sv
// Two-master round-robin arbiter in front of the single-port RAM bus.
// Optional ack timeout with sticky o_err is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_2m #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
`ifdef ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic                i_clk,
    input  logic                rst,

    input  logic                i_m0_bus_en,
    input  logic                i_m0_wr_en,
    input  logic [DATA_W/8-1:0] i_m0_byte_en,
    input  logic [DATA_W-1:0]   i_m0_wr_data,
    input  logic [ADDR_W-1:0]   i_m0_addr,
    output logic                o_m0_ack,
    output logic [DATA_W-1:0]   o_m0_rd_data,

    input  logic                i_m1_bus_en,
    input  logic                i_m1_wr_en,
    input  logic [DATA_W/8-1:0] i_m1_byte_en,
    input  logic [DATA_W-1:0]   i_m1_wr_data,
    input  logic [ADDR_W-1:0]   i_m1_addr,
    output logic                o_m1_ack,
    output logic [DATA_W-1:0]   o_m1_rd_data,

    output logic                o_s_cs,
    output logic                o_s_wr_en,
    output logic [DATA_W/8-1:0] o_s_byte_en,
    output logic [DATA_W-1:0]   o_s_wr_data,
    output logic [ADDR_W-1:0]   o_s_addr,
    input  logic                i_s_ack,
    input  logic [DATA_W-1:0]   i_s_rd_data
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                o_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic   last_grant;
    logic   last_grant_next;
    logic   timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF;

    logic [CNT_W-1:0] cnt;
    logic             err_q;
    logic             granted_req;

    assign granted_req = ((state == GNT0) && i_m0_bus_en) ||
                         ((state == GNT1) && i_m1_bus_en);

    // Fires in the TIMEOUT-th granted cycle that passes without a slave ack.
    assign timeout_hit = granted_req && !i_s_ack && (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            cnt   <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE || state_next != state) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            if (timeout_hit) begin
                err_q <= 1'b1;
            end
        end
    end

    assign o_err = rst & (err_q | timeout_hit);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (!rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end

    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        o_s_cs          = 1'b0;
        o_s_wr_en       = 1'b0;
        o_s_byte_en     = '0;
        o_s_wr_data     = '0;
        o_s_addr        = '0;
        o_m0_ack        = 1'b0;
        o_m0_rd_data    = '0;
        o_m1_ack        = 1'b0;
        o_m1_rd_data    = '0;

        case (state)
            IDLE: begin
                if (i_m0_bus_en && i_m1_bus_en) begin
                    state_next = last_grant ? GNT0 : GNT1;
                end else if (i_m0_bus_en) begin
                    state_next = GNT0;
                end else if (i_m1_bus_en) begin
                    state_next = GNT1;
                end
            end

            GNT0: begin
                o_s_cs      = i_m0_bus_en & ~timeout_hit;
                o_s_wr_en   = i_m0_wr_en;
                o_s_byte_en = i_m0_byte_en;
                o_s_wr_data = i_m0_wr_data;
                o_s_addr    = i_m0_addr;
                o_m0_ack    = i_s_ack | timeout_hit;
                o_m0_rd_data = i_s_rd_data;
`ifdef ARB_TIMEOUT_EN
                if (timeout_hit) begin
                    o_m0_rd_data = DATA_W'(TIMEOUT_DATA);
                end
`endif
                // A waiting master 1 is handed the bus directly, without an IDLE bubble.
                if (i_s_ack || timeout_hit) begin
                    last_grant_next = 1'b0;
                    state_next      = i_m1_bus_en ? GNT1 : IDLE;
                end else if (!i_m0_bus_en) begin
                    state_next = IDLE;
                end
            end

            GNT1: begin
                o_s_cs      = i_m1_bus_en & ~timeout_hit;
                o_s_wr_en   = i_m1_wr_en;
                o_s_byte_en = i_m1_byte_en;
                o_s_wr_data = i_m1_wr_data;
                o_s_addr    = i_m1_addr;
                o_m1_ack    = i_s_ack | timeout_hit;
                o_m1_rd_data = i_s_rd_data;
`ifdef ARB_TIMEOUT_EN
                if (timeout_hit) begin
                    o_m1_rd_data = DATA_W'(TIMEOUT_DATA);
                end
`endif
                if (i_s_ack || timeout_hit) begin
                    last_grant_next = 1'b1;
                    state_next      = i_m0_bus_en ? GNT0 : IDLE;
                end else if (!i_m1_bus_en) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase

        // A reset cycle swallows any in-flight ack and silences the bus.
        if (!rst) begin
            state_next      = IDLE;
            last_grant_next = 1'b1;
            o_s_cs          = 1'b0;
            o_s_wr_en       = 1'b0;
            o_s_byte_en     = '0;
            o_s_wr_data     = '0;
            o_s_addr        = '0;
            o_m0_ack        = 1'b0;
            o_m0_rd_data    = '0;
            o_m1_ack        = 1'b0;
            o_m1_rd_data    = '0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_2m.sv
// Directed self-checking bench for bus_arbiter_2m; timeout scenario runs when ARB_TIMEOUT_EN is defined.
module tb_bus_arbiter_2m;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              i_clk = 1'b0;
    logic              rst;
    logic              i_m0_bus_en, i_m0_wr_en;
    logic [3:0]        i_m0_byte_en;
    logic [DATA_W-1:0] i_m0_wr_data;
    logic [ADDR_W-1:0] i_m0_addr;
    logic              o_m0_ack;
    logic [DATA_W-1:0] o_m0_rd_data;
    logic              i_m1_bus_en, i_m1_wr_en;
    logic [3:0]        i_m1_byte_en;
    logic [DATA_W-1:0] i_m1_wr_data;
    logic [ADDR_W-1:0] i_m1_addr;
    logic              o_m1_ack;
    logic [DATA_W-1:0] o_m1_rd_data;
    logic              o_s_cs, o_s_wr_en;
    logic [3:0]        o_s_byte_en;
    logic [DATA_W-1:0] o_s_wr_data;
    logic [ADDR_W-1:0] o_s_addr;
    logic              i_s_ack;
    logic [DATA_W-1:0] i_s_rd_data;

    int tests_run    = 0;
    int tests_failed = 0;

`ifdef ARB_TIMEOUT_EN
    logic o_err;
    bus_arbiter_2m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(4)) dut (
`else
    bus_arbiter_2m #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
`endif
        .i_clk(i_clk), .rst(rst),
        .i_m0_bus_en(i_m0_bus_en), .i_m0_wr_en(i_m0_wr_en), .i_m0_byte_en(i_m0_byte_en),
        .i_m0_wr_data(i_m0_wr_data), .i_m0_addr(i_m0_addr),
        .o_m0_ack(o_m0_ack), .o_m0_rd_data(o_m0_rd_data),
        .i_m1_bus_en(i_m1_bus_en), .i_m1_wr_en(i_m1_wr_en), .i_m1_byte_en(i_m1_byte_en),
        .i_m1_wr_data(i_m1_wr_data), .i_m1_addr(i_m1_addr),
        .o_m1_ack(o_m1_ack), .o_m1_rd_data(o_m1_rd_data),
        .o_s_cs(o_s_cs), .o_s_wr_en(o_s_wr_en), .o_s_byte_en(o_s_byte_en),
        .o_s_wr_data(o_s_wr_data), .o_s_addr(o_s_addr),
        .i_s_ack(i_s_ack), .i_s_rd_data(i_s_rd_data)
`ifdef ARB_TIMEOUT_EN
        , .o_err(o_err)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_inputs();
        i_m0_bus_en = 0; i_m0_wr_en = 0; i_m0_byte_en = 0; i_m0_wr_data = 0; i_m0_addr = 0;
        i_m1_bus_en = 0; i_m1_wr_en = 0; i_m1_byte_en = 0; i_m1_wr_data = 0; i_m1_addr = 0;
        i_s_ack = 0; i_s_rd_data = 0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clear_inputs();
        i_m0_bus_en = 1; i_m1_bus_en = 1; i_s_ack = 1;
        #1;
        tests_run++;
        if (o_s_cs !== 1'b0 || o_m0_ack !== 1'b0 || o_m1_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: cs/ack0/ack1 got %b%b%b expected 000", o_s_cs, o_m0_ack, o_m1_ack);
        end
        tick();
        rst = 1'b1;
        clear_inputs();
        #1;
        tests_run++;
        if (o_s_cs !== 1'b0 || o_m0_ack !== 1'b0 || o_m1_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: cs/ack0/ack1 got %b%b%b expected 000", o_s_cs, o_m0_ack, o_m1_ack);
        end
    endtask

    task automatic test_single_write();
        int m0_acks = 0;
        do_reset();
        i_m0_bus_en = 1; i_m0_wr_en = 1; i_m0_byte_en = 4'hF;
        i_m0_addr = 32'h8000_0010; i_m0_wr_data = 32'h1234_5678;
        #1;
        tests_run++;
        if (o_s_cs !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL write_arb_cycle: cs got %b expected 0", o_s_cs);
        end
        tick();
        #1;
        if (o_m0_ack) m0_acks++;
        tests_run++;
        if (o_s_cs !== 1'b1 || o_s_wr_en !== 1'b1 || o_s_byte_en !== 4'hF) begin
            tests_failed++;
            $display("[TB] FAIL write_grant: cs/wr/be got %b/%b/%h expected 1/1/f", o_s_cs, o_s_wr_en, o_s_byte_en);
        end
        tests_run++;
        if (o_s_addr !== 32'h8000_0010 || o_s_wr_data !== 32'h1234_5678) begin
            tests_failed++;
            $display("[TB] FAIL write_payload: addr/data got %h/%h expected 80000010/12345678", o_s_addr, o_s_wr_data);
        end
        tick();
        i_s_ack = 1;
        #1;
        if (o_m0_ack) m0_acks++;
        tests_run++;
        if (o_m0_ack !== 1'b1 || o_m1_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL write_ack: ack0/ack1 got %b/%b expected 1/0", o_m0_ack, o_m1_ack);
        end
        tick();
        clear_inputs();
        #1;
        if (o_m0_ack) m0_acks++;
        tests_run++;
        if (o_s_cs !== 1'b0 || m0_acks != 1) begin
            tests_failed++;
            $display("[TB] FAIL write_done: cs got %b expected 0, ack pulses got %0d expected 1", o_s_cs, m0_acks);
        end
    endtask

    task automatic test_both_read();
        do_reset();
        i_m0_bus_en = 1; i_m0_addr = 32'h0000_0100;
        i_m1_bus_en = 1; i_m1_addr = 32'h0000_0200;
        #1;
        tick();
        i_s_ack = 1; i_s_rd_data = 32'hAAAA_0000;
        #1;
        tests_run++;
        if (o_s_cs !== 1'b1 || o_s_addr !== 32'h0000_0100 || o_m0_ack !== 1'b1 || o_m1_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL both_first_m0: cs/addr/ack0/ack1 got %b/%h/%b/%b expected 1/00000100/1/0",
                     o_s_cs, o_s_addr, o_m0_ack, o_m1_ack);
        end
        tests_run++;
        if (o_m0_rd_data !== 32'hAAAA_0000) begin
            tests_failed++;
            $display("[TB] FAIL both_rd0: got %h expected aaaa0000", o_m0_rd_data);
        end
        tick();
        i_m0_bus_en = 0; i_s_rd_data = 32'hBBBB_0001;
        #1;
        tests_run++;
        if (o_s_cs !== 1'b1 || o_s_addr !== 32'h0000_0200 || o_m1_ack !== 1'b1 || o_m0_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL both_then_m1: cs/addr/ack1/ack0 got %b/%h/%b/%b expected 1/00000200/1/0",
                     o_s_cs, o_s_addr, o_m1_ack, o_m0_ack);
        end
        tests_run++;
        if (o_m1_rd_data !== 32'hBBBB_0001) begin
            tests_failed++;
            $display("[TB] FAIL both_rd1: got %h expected bbbb0001", o_m1_rd_data);
        end
        tick();
        clear_inputs();
        #1;
        tests_run++;
        if (o_s_cs !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL both_idle: cs got %b expected 0", o_s_cs);
        end
    endtask

    task automatic test_fairness();
        int n0 = 0;
        int n1 = 0;
        do_reset();
        i_m0_bus_en = 1; i_m0_addr = 32'h10;
        i_m1_bus_en = 1; i_m1_addr = 32'h20;
        #1;
        tick();
        for (int i = 0; i < 8; i++) begin
            logic exp0;
            i_s_ack = 1;
            i_s_rd_data = 32'h100 + i;
            exp0 = (i % 2 == 0);
            #1;
            if (o_m0_ack) n0++;
            if (o_m1_ack) n1++;
            tests_run++;
            if (o_m0_ack !== exp0 || o_m1_ack !== ~exp0 || o_s_cs !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL fair_order[%0d]: ack0/ack1/cs got %b/%b/%b expected %b/%b/1",
                         i, o_m0_ack, o_m1_ack, o_s_cs, exp0, ~exp0);
            end
            tick();
        end
        tests_run++;
        if (n0 != 4 || n1 != 4) begin
            tests_failed++;
            $display("[TB] FAIL fair_count: m0/m1 grants got %0d/%0d expected 4/4", n0, n1);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        i_m1_bus_en = 1; i_m1_addr = 32'h0000_0300;
        #1;
        tick();
        #1;
        tests_run++;
        if (o_s_cs !== 1'b1 || o_s_addr !== 32'h0000_0300) begin
            tests_failed++;
            $display("[TB] FAIL abort_grant1: cs/addr got %b/%h expected 1/00000300", o_s_cs, o_s_addr);
        end
        tick();
        i_m1_bus_en = 0;
        i_m0_bus_en = 1; i_m0_addr = 32'h0000_0400;
        #1;
        tests_run++;
        if (o_s_cs !== 1'b0 || o_m0_ack !== 1'b0 || o_m1_ack !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_drop: cs/ack0/ack1 got %b/%b/%b expected 0/0/0", o_s_cs, o_m0_ack, o_m1_ack);
        end
        tick();
        #1;
        tests_run++;
        if (o_s_cs !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL abort_idle: cs got %b expected 0", o_s_cs);
        end
        tick();
        i_s_ack = 1;
        #1;
        tests_run++;
        if (o_s_cs !== 1'b1 || o_s_addr !== 32'h0000_0400 || o_m0_ack !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL abort_regrant0: cs/addr/ack0 got %b/%h/%b expected 1/00000400/1",
                     o_s_cs, o_s_addr, o_m0_ack);
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        i_m0_bus_en = 1; i_m0_addr = 32'h0000_0500;
        #1;
        tick();
        #1;
        tests_run++;
        if (o_s_cs !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL midrst_grant: cs got %b expected 1", o_s_cs);
        end
        tick();
        rst = 1'b0;
        i_s_ack = 1;
        #1;
        tests_run++;
        if (o_m0_ack !== 1'b0 || o_s_cs !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_ack: ack0/cs got %b/%b expected 0/0", o_m0_ack, o_s_cs);
        end
        tick();
        rst = 1'b1;
        i_m0_bus_en = 0;
        i_s_ack = 1;
        #1;
        tests_run++;
        if (o_s_cs !== 1'b0 || o_m0_ack !== 1'b0 || o_m1_ack !== 1'b0 || o_s_addr !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL midrst_after: cs/ack0/ack1/addr got %b/%b/%b/%h expected 0/0/0/00000000",
                     o_s_cs, o_m0_ack, o_m1_ack, o_s_addr);
        end
        clear_inputs();
        tick();
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        i_m0_bus_en = 1; i_m0_addr = 32'h0000_0600;
        #1;
        tick();
        for (int c = 1; c <= 3; c++) begin
            #1;
            tests_run++;
            if (o_m0_ack !== 1'b0 || o_err !== 1'b0 || o_s_cs !== 1'b1) begin
                tests_failed++;
                $display("[TB] FAIL tmo_wait[%0d]: ack0/err/cs got %b/%b/%b expected 0/0/1", c, o_m0_ack, o_err, o_s_cs);
            end
            tick();
        end
        #1;
        tests_run++;
        if (o_m0_ack !== 1'b1 || o_m0_rd_data !== 32'hDEAD_BEEF || o_s_cs !== 1'b0 || o_err !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL tmo_fire: ack0/rd/cs/err got %b/%h/%b/%b expected 1/deadbeef/0/1",
                     o_m0_ack, o_m0_rd_data, o_s_cs, o_err);
        end
        tick();
        i_m0_bus_en = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            tests_run++;
            if (o_err !== 1'b1 || o_m0_ack !== 1'b0) begin
                tests_failed++;
                $display("[TB] FAIL tmo_sticky[%0d]: err/ack0 got %b/%b expected 1/0", c, o_err, o_m0_ack);
            end
            tick();
        end
        do_reset();
        #1;
        tests_run++;
        if (o_err !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL tmo_clear: err got %b expected 0", o_err);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b0;
        clear_inputs();
        #1;
        test_reset();
        test_single_write();
        test_both_read();
        test_fairness();
        test_abort();
        test_reset_mid();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
